// File: rtl/random_state_pkg.sv
// rtl/random_state_pkg.sv - shared types and helpers for the random state generator
// Contents:
//   mode_e          duration mode (RANDOM, FIXED_MIN, FIXED_MAX, HOLD)
//   LFSR_TAPS       Galois feedback taps, right-shifting LFSR
//   SEED_SPREAD     per-channel seed multiplier
//   lfsr_next       one LFSR step
//   channel_seed    base seed spread to a channel, never zero
//   scale_duration  map a random draw onto [min, max]
package random_state_pkg;

  typedef enum logic [1:0] {
    RANDOM    = 2'd0,
    FIXED_MIN = 2'd1,
    FIXED_MAX = 2'd2,
    HOLD      = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] SEED_SPREAD = 32'h9E37_79B9;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    lfsr_next = {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // An all-zero Galois LFSR is stuck forever, so zero is replaced by 1.
  function automatic logic [31:0] channel_seed(input logic [31:0] base,
                                               input logic [31:0] idx);
    logic [31:0] s;
    s = base ^ (idx * SEED_SPREAD);
    channel_seed = (s == 32'h0) ? 32'h1 : s;
  endfunction

  // rnd < 2**width, so the scaled offset is strictly below (max-min+1):
  // the result always lands in [min, max] with no modulo bias spikes.
  function automatic logic [31:0] scale_duration(input logic [31:0] rnd,
                                                 input logic [31:0] min_val,
                                                 input logic [31:0] max_val,
                                                 input int unsigned width);
    logic [63:0] prod;
    prod = {32'h0, rnd} * {32'h0, (max_val - min_val + 32'd1)};
    scale_duration = min_val + 32'(prod >> width);
  endfunction

endpackage

// File: rtl/random_state_channel.sv
// rtl/random_state_channel.sv - one channel: LFSR, duration counter, level FSM
// Ports:
//   i_clk, i_a_rst       clock, asynchronous active-high reset
//   i_en, i_mode         run enable and duration mode (shared by all channels)
//   i_seed_load, i_seed  synchronous reseed strobe and base seed
//   o_state, o_edge      channel level and one-cycle change pulse
module random_state_channel
  import random_state_pkg::*;
#(
  parameter int          CNT_WIDTH       = 16,
  parameter int          STATE_0_MIN_VAL = 100,
  parameter int          STATE_0_MAX_VAL = 600,
  parameter int          STATE_1_MIN_VAL = 60,
  parameter int          STATE_1_MAX_VAL = 500,
  parameter logic [31:0] DEFAULT_SEED    = 32'hACE1_2021,
  parameter int unsigned CH_IDX          = 0
) (
  input  logic        i_clk,
  input  logic        i_a_rst,
  input  logic        i_en,
  input  logic [1:0]  i_mode,
  input  logic        i_seed_load,
  input  logic [31:0] i_seed,
  output logic        o_state,
  output logic        o_edge
);

  localparam logic [31:0] S0_MIN = 32'(STATE_0_MIN_VAL);
  localparam logic [31:0] S0_MAX = 32'(STATE_0_MAX_VAL);
  localparam logic [31:0] S1_MIN = 32'(STATE_1_MIN_VAL);
  localparam logic [31:0] S1_MAX = 32'(STATE_1_MAX_VAL);
  localparam logic [31:0] IDX    = 32'(CH_IDX);
  // First state-0 interval after reset/reseed is always the minimum.
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(STATE_0_MIN_VAL - 1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [31:0]          r_lfsr;
  logic                 r_state;
  logic                 r_edge;

  mode_e       w_mode;
  logic        w_run;
  logic [31:0] w_rnd;
  logic [31:0] w_min;
  logic [31:0] w_max;
  logic [31:0] w_dur;
  logic [31:0] w_reset_seed;
  logic [31:0] w_load_seed;

  always_comb begin
    w_mode       = mode_e'(i_mode);
    w_run        = i_en && (w_mode != HOLD);
    w_rnd        = 32'(r_lfsr[CNT_WIDTH-1:0]);
    // The draw is for the level being entered, i.e. the opposite of r_state.
    w_min        = r_state ? S0_MIN : S1_MIN;
    w_max        = r_state ? S0_MAX : S1_MAX;
    w_reset_seed = channel_seed(DEFAULT_SEED, IDX);
    w_load_seed  = channel_seed(i_seed, IDX);
    case (w_mode)
      FIXED_MIN: w_dur = w_min;
      FIXED_MAX: w_dur = w_max;
      default:   w_dur = scale_duration(w_rnd, w_min, w_max, CNT_WIDTH);
    endcase
  end

  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      r_state <= 1'b0;
      r_edge  <= 1'b0;
      r_cnt   <= CNT_INIT;
      r_lfsr  <= w_reset_seed;
    end else if (i_seed_load) begin
      r_state <= 1'b0;
      r_edge  <= 1'b0;
      r_cnt   <= CNT_INIT;
      r_lfsr  <= w_load_seed;
    end else if (w_run) begin
      if (r_cnt != '0) begin
        r_cnt  <= r_cnt - 1'b1;
        r_edge <= 1'b0;
      end else begin
        r_state <= ~r_state;
        r_edge  <= 1'b1;
        r_cnt   <= CNT_WIDTH'(w_dur - 32'd1);
        r_lfsr  <= lfsr_next(r_lfsr);
      end
    end else begin
      r_edge <= 1'b0;
    end
  end

  assign o_state = r_state;
  assign o_edge  = r_edge;

endmodule

// File: rtl/random_state_generator_mc.sv
// rtl/random_state_generator_mc.sv - multi-channel bounded random level generator
// Ports:
//   i_clk, i_a_rst       clock, asynchronous active-high reset
//   i_en                 run enable, low freezes every channel
//   i_mode               0 random, 1 fixed-min, 2 fixed-max, 3 hold
//   i_seed_load, i_seed  synchronous reseed strobe and base seed
//   o_state              per-channel level
//   o_edge               per-channel one-cycle pulse on each level change
module random_state_generator_mc
  import random_state_pkg::*;
#(
  parameter int          CHANNEL_NUM     = 4,
  parameter int          CNT_WIDTH       = 16,
  parameter int          STATE_0_MIN_VAL = 100,
  parameter int          STATE_0_MAX_VAL = 600,
  parameter int          STATE_1_MIN_VAL = 60,
  parameter int          STATE_1_MAX_VAL = 500,
  parameter logic [31:0] DEFAULT_SEED    = 32'hACE1_2021
) (
  input  logic                   i_clk,
  input  logic                   i_a_rst,
  input  logic                   i_en,
  input  logic [1:0]             i_mode,
  input  logic                   i_seed_load,
  input  logic [31:0]            i_seed,
  output logic [CHANNEL_NUM-1:0] o_state,
  output logic [CHANNEL_NUM-1:0] o_edge
);

  localparam longint CNT_LIMIT = (64'd1 << CNT_WIDTH) - 64'd1;

  if (CHANNEL_NUM < 1) begin : g_bad_ch
    $error("CHANNEL_NUM must be at least 1");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_width
    $error("CNT_WIDTH must be in 1..32");
  end
  if (STATE_0_MIN_VAL < 1 || STATE_0_MIN_VAL > STATE_0_MAX_VAL) begin : g_bad_s0
    $error("state 0 bounds must satisfy 1 <= MIN <= MAX");
  end
  if (STATE_1_MIN_VAL < 1 || STATE_1_MIN_VAL > STATE_1_MAX_VAL) begin : g_bad_s1
    $error("state 1 bounds must satisfy 1 <= MIN <= MAX");
  end
  if (longint'(STATE_0_MAX_VAL) > CNT_LIMIT || longint'(STATE_1_MAX_VAL) > CNT_LIMIT) begin : g_bad_max
    $error("state MAX values must fit in CNT_WIDTH bits");
  end

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    random_state_channel #(
      .CNT_WIDTH       (CNT_WIDTH),
      .STATE_0_MIN_VAL (STATE_0_MIN_VAL),
      .STATE_0_MAX_VAL (STATE_0_MAX_VAL),
      .STATE_1_MIN_VAL (STATE_1_MIN_VAL),
      .STATE_1_MAX_VAL (STATE_1_MAX_VAL),
      .DEFAULT_SEED    (DEFAULT_SEED),
      .CH_IDX          (c)
    ) u_channel (
      .i_clk       (i_clk),
      .i_a_rst     (i_a_rst),
      .i_en        (i_en),
      .i_mode      (i_mode),
      .i_seed_load (i_seed_load),
      .i_seed      (i_seed),
      .o_state     (o_state[c]),
      .o_edge      (o_edge[c])
    );
  end

endmodule

// File: tb/tb_random_state_generator_mc.sv
// tb/tb_random_state_generator_mc.sv - directed self-checking bench for random_state_generator_mc
module tb_random_state_generator_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        seed_load;
  logic [31:0] seed;
  logic [3:0]  st;
  logic [3:0]  ed;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n;
  int a2;
  int b2;
  logic [3:0] edge_or;

  always #5 clk = ~clk;

  random_state_generator_mc dut (
    .i_clk       (clk),
    .i_a_rst     (rst),
    .i_en        (en),
    .i_mode      (mode),
    .i_seed_load (seed_load),
    .i_seed      (seed),
    .o_state     (st),
    .o_edge      (ed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts clock cycles (sampled at negedge) until o_edge[ch] pulses.
  task automatic measure(input int ch, output int len);
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (!ed[ch] && len < 3000);
    if (!ed[ch]) check("edge_timeout", 32'(ed[ch]), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd1; seed_load = 1'b0; seed = 32'h0;
    #1;
    check("reset_state", 32'(st), 32'h0);
    check("reset_edge", 32'(ed), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; en = 1'b1;

    // Fixed-min: 100 / 60 period, all channels in lock-step
    measure(0, n); check("fmin_s0_first", n, 100);
    check("fmin_all_state1", 32'(st), 32'hF);
    check("fmin_all_edge", 32'(ed), 32'hF);
    measure(0, n); check("fmin_s1", n, 60);
    check("fmin_all_state0", 32'(st), 32'h0);
    measure(0, n); check("fmin_s0", n, 100);
    measure(0, n); check("fmin_s1_b", n, 60);

    // Enable gap of 50 cycles after 40 cycles of state 0 -> 150 wall cycles
    repeat (40) @(negedge clk);
    en = 1'b0; edge_or = 4'h0;
    repeat (50) begin @(negedge clk); edge_or |= ed; end
    en = 1'b1;
    measure(0, n); check("gap_remaining", n, 60);
    check("gap_no_edge", 32'(edge_or), 32'h0);
    check("gap_state1", 32'(st[0]), 32'h1);

    // Hold mode for 20 cycles after 10 cycles of state 1 -> 50 remaining
    repeat (10) @(negedge clk);
    mode = 2'd3; edge_or = 4'h0;
    repeat (20) begin @(negedge clk); edge_or |= ed; end
    mode = 2'd1;
    measure(0, n); check("hold_remaining", n, 50);
    check("hold_no_edge", 32'(edge_or), 32'h0);

    // Mode change mid-interval keeps the current count, applies at next draw
    repeat (30) @(negedge clk);
    mode = 2'd2;
    measure(0, n); check("modechg_remaining", n, 70);
    measure(0, n); check("fmax_s1", n, 500);
    measure(0, n); check("fmax_s0", n, 600);

    // Seed load mid state 1 with seed 0 (channel 0 uses seed 1)
    repeat (20) @(negedge clk);
    check("pre_load_state1", 32'(st[0]), 32'h1);
    seed = 32'h0; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; mode = 2'd0;
    check("load_state", 32'(st), 32'h0);
    check("load_edge", 32'(ed), 32'h0);
    // Channel 0, lfsr 1 -> 0x80200003 -> 0xC0300002: draws 60, 100, 60
    measure(0, n); check("rnd_ch0_s0", n, 100);
    measure(0, n); check("rnd_ch0_s1", n, 60); a2 = n;
    measure(0, n); check("rnd_ch0_s0b", n, 100);
    measure(0, n); check("rnd_ch0_s1b", n, 60);

    // Reload the same seed; channel 1 (seed 0x9E3779B9) draws 269 then 469
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    measure(1, n); check("rnd_ch1_s0", n, 100);
    measure(1, n); check("rnd_ch1_s1", n, 269); b2 = n;
    measure(1, n); check("rnd_ch1_s0b", n, 469);
    check("channels_differ", 32'(a2 != b2), 32'h1);

    // Async reset mid state 1 of channel 1
    mode = 2'd1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("pre_reset_state1", 32'(st[1]), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_state", 32'(st), 32'h0);
    check("async_reset_edge", 32'(ed), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    measure(0, n); check("post_reset_s0", n, 100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
